// File: rtl/cc_mac_neuron_pkg.sv
// cc_mac_neuron_pkg: shared FSM states, default parameters and accumulator sizing for the MAC neuron.
package cc_mac_neuron_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, DONE} state_t;
  localparam int DEF_DATAWIDTH = 8;
  localparam int DEF_INPUTS = 4;
  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction
endpackage

// File: rtl/cc_mac_neuron_cmp.sv
// cc_mac_neuron_cmp: reduces the accumulator to operand width and compares against the threshold.
// CC_MAC_NEURON_SATURATE_EN selects clamping; otherwise the low bits are kept (modulo).
module cc_mac_neuron_cmp #(
  parameter int NUMBER_DATAWIDTH = 8,
  parameter int ACC_WIDTH = 18
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [NUMBER_DATAWIDTH-1:0] t0,
  output logic ge
);
`ifdef CC_MAC_NEURON_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic [NUMBER_DATAWIDTH-1:0] red;
  assign red = (SAT && |acc[ACC_WIDTH-1:NUMBER_DATAWIDTH]) ? '1 : acc[NUMBER_DATAWIDTH-1:0];
  assign ge = red >= t0;
endmodule

// File: rtl/cc_mac_neuron.sv
// cc_mac_neuron: threshold neuron summing NUMBER_INPUTS unsigned x*w products, then y0 = reduced >= t0.
// Optional clamp on reduction via CC_MAC_NEURON_SATURATE_EN (see cc_mac_neuron_cmp).
module cc_mac_neuron
  import cc_mac_neuron_pkg::*;
#(
  parameter int NUMBER_DATAWIDTH = DEF_DATAWIDTH,
  parameter int NUMBER_INPUTS = DEF_INPUTS
) (
  input  logic CC_MAC_NEURON_CLOCK_50,
  input  logic CC_MAC_NEURON_RESET_InHigh,
  input  logic CC_MAC_NEURON_start_In,
  input  logic [NUMBER_DATAWIDTH-1:0] CC_MAC_NEURON_t0_InBUS,
  input  logic [NUMBER_DATAWIDTH-1:0] CC_MAC_NEURON_x_InBUS,
  input  logic [NUMBER_DATAWIDTH-1:0] CC_MAC_NEURON_w_InBUS,
  input  logic CC_MAC_NEURON_valid_In,
  output logic CC_MAC_NEURON_ready_Out,
  output logic CC_MAC_NEURON_y0_Out,
  output logic CC_MAC_NEURON_valid_Out,
  input  logic CC_MAC_NEURON_ready_In,
  output logic CC_MAC_NEURON_busy_Out
);
  localparam int ACC_WIDTH = acc_width(NUMBER_DATAWIDTH, NUMBER_INPUTS);
  localparam int CW = $clog2(NUMBER_INPUTS + 1);
  state_t state, state_n;
  logic [ACC_WIDTH-1:0] acc;
  logic [CW-1:0] cnt;
  logic [NUMBER_DATAWIDTH-1:0] t0;
  logic y0, ge, beat, last, go;
  assign go = state == IDLE && CC_MAC_NEURON_start_In;
  assign beat = state == ACCUM && CC_MAC_NEURON_valid_In;
  assign last = beat && cnt == CW'(NUMBER_INPUTS - 1);
  always_ff @(posedge CC_MAC_NEURON_CLOCK_50)
    state <= CC_MAC_NEURON_RESET_InHigh ? IDLE : state_n;
  always_comb begin
    state_n = state;
    state_n = go ? ACCUM :
              last ? COMPARE :
              state == COMPARE ? DONE :
              (state == DONE && CC_MAC_NEURON_ready_In) ? IDLE : state;
  end
  always_ff @(posedge CC_MAC_NEURON_CLOCK_50) begin
    if (CC_MAC_NEURON_RESET_InHigh) begin
      acc <= '0;
      cnt <= '0;
      t0 <= '0;
      y0 <= 1'b0;
    end else begin
      if (go) begin
        t0 <= CC_MAC_NEURON_t0_InBUS;
        acc <= '0;
        cnt <= '0;
      end
      if (beat) begin
        acc <= acc + ACC_WIDTH'(CC_MAC_NEURON_x_InBUS) * ACC_WIDTH'(CC_MAC_NEURON_w_InBUS);
        cnt <= cnt + CW'(1);
      end
      if (state == COMPARE) y0 <= ge;
    end
  end
  cc_mac_neuron_cmp #(
    .NUMBER_DATAWIDTH(NUMBER_DATAWIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_cmp (
    .acc(acc),
    .t0(t0),
    .ge(ge)
  );
  assign CC_MAC_NEURON_ready_Out = state == ACCUM;
  assign CC_MAC_NEURON_valid_Out = state == DONE;
  assign CC_MAC_NEURON_busy_Out = state != IDLE;
  assign CC_MAC_NEURON_y0_Out = y0;
endmodule

// File: doc/cc_mac_neuron.md
CC_MAC_NEURON -- requirements
Module: cc_mac_neuron

Interface
REQ-001 Parameter NUMBER_DATAWIDTH, default 8, SHALL set the width of the x, w and threshold operands.
REQ-002 Parameter NUMBER_INPUTS, default 4, range 2..64, SHALL set the number of x/w pairs per evaluation.
REQ-003 Constant ACC_WIDTH SHALL equal 2*NUMBER_DATAWIDTH + clog2(NUMBER_INPUTS).
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 CC_MAC_NEURON_CLOCK_50  in  1  sole clock, rising edge.
REQ-006 CC_MAC_NEURON_RESET_InHigh  in  1  synchronous active-high reset.
REQ-007 CC_MAC_NEURON_start_In  in  1  one-cycle request to begin an evaluation.
REQ-008 CC_MAC_NEURON_t0_InBUS  in  NUMBER_DATAWIDTH  unsigned threshold, sampled with start.
REQ-009 CC_MAC_NEURON_x_InBUS  in  NUMBER_DATAWIDTH  unsigned input sample.
REQ-010 CC_MAC_NEURON_w_InBUS  in  NUMBER_DATAWIDTH  unsigned weight.
REQ-011 CC_MAC_NEURON_valid_In  in  1  x/w pair valid.
REQ-012 CC_MAC_NEURON_ready_Out  out  1  block accepts a pair.
REQ-013 CC_MAC_NEURON_y0_Out  out  1  neuron decision.
REQ-014 CC_MAC_NEURON_valid_Out  out  1  y0 valid.
REQ-015 CC_MAC_NEURON_ready_In  in  1  consumer accepts y0.
REQ-016 CC_MAC_NEURON_busy_Out  out  1  high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, ACCUM, COMPARE and DONE.
REQ-018 IDLE: start_In=1 SHALL latch t0, clear the accumulator and the beat counter, and move to ACCUM on the next edge; valid_In SHALL be ignored in IDLE.
REQ-019 ready_Out SHALL be 1 only in ACCUM.
REQ-020 A beat SHALL be accepted when valid_In and ready_Out are both 1.
REQ-021 Each accepted beat SHALL add the full-width product x*w into the ACC_WIDTH accumulator and increment the counter.
REQ-022 Cycles with valid_In=0 SHALL change no state.
REQ-023 On the NUMBER_INPUTS-th accepted beat, the FSM SHALL move to COMPARE; ready_Out SHALL fall the next cycle.
REQ-024 COMPARE SHALL reduce the accumulator to NUMBER_DATAWIDTH bits per REQ-032/033, register y0 = (reduced >= t0), then move to DONE.
REQ-025 DONE SHALL hold valid_Out=1 with y0 stable until ready_In=1, then return to IDLE on that edge.
REQ-026 start_In SHALL be ignored outside IDLE.
REQ-027 Latency from the last accepted beat to valid_Out SHALL be 2 cycles.
REQ-028 With ready_In held high, the minimum cycle time per evaluation SHALL be NUMBER_INPUTS+3 cycles.
REQ-029 All arithmetic SHALL be unsigned, and the accumulator SHALL never overflow internally.

Reset
REQ-030 Reset SHALL force IDLE and clear the accumulator, counter and latched t0; y0_Out, valid_Out, ready_Out and busy_Out SHALL all be 0.
REQ-031 Reset asserted in any state, including mid-ACCUM, SHALL discard the partial evaluation, with no output pulse afterwards.

Configuration
REQ-032 With macro CC_MAC_NEURON_SATURATE_EN defined, an accumulator value above 2^NUMBER_DATAWIDTH-1 SHALL clamp to 2^NUMBER_DATAWIDTH-1 before the compare.
REQ-033 With CC_MAC_NEURON_SATURATE_EN undefined, the reduction SHALL be truncation to the low NUMBER_DATAWIDTH bits, which is legacy modulo behaviour.

Structure
REQ-034 A shared package cc_mac_neuron_pkg SHALL hold the FSM state typedef, the ACC_WIDTH function and the default parameter constants.
REQ-035 The reduction-plus-compare logic SHALL be one sub-module, cc_mac_neuron_cmp, parametrised by NUMBER_DATAWIDTH and ACC_WIDTH.

Verification (DW=8, N=4)
REQ-036 x={1,2,3,4}, w={1,1,1,1}, t0=10 -> y0=1; repeated with t0=11 -> y0=0; valid_Out rises 2 cycles after beat 4.
REQ-037 x=w=16 on all beats (sum 1024), t0=1 -> y0=0 without the macro (1024 mod 256 = 0); y0=1 with the macro (clamped to 255).
REQ-038 ready_In held low for 5 cycles in DONE, with start_In pulsed -> valid_Out and y0 stay stable, start is ignored, and IDLE is entered on the ready_In edge.
REQ-039 Three-cycle valid_In bubbles between beats of REQ-036 -> identical result; exactly 4 beats counted; ready_Out=0 after beat 4.
REQ-040 Reset asserted after 2 accepted beats -> outputs 0 and state IDLE next cycle; a following full REQ-036 transaction gives y0=1 with no residue.
